// File: rtl/femto_ahb_bridge.sv
// FemtoRV32 native bus (rstrb/wmask pulses, busy back-pressure) to AHB-Lite single-transfer master.
// Optional data-phase timeout: define FEMTO_AHB_BRIDGE_TIMEOUT_EN.
module femto_ahb_bridge #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_wbusy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        err_sticky,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("femto_ahb_bridge: TIMEOUT_CYCLES out of range 1..65535");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rbusy_q, rbusy_d;
  logic        wbusy_q, wbusy_d;
  logic        err_q, err_d;

  logic [2:0]  dec_size;
  logic [1:0]  dec_off;
  logic        wr_req;
  logic        req;
  logic        tmo_abort;
  logic        xfer_end;

  // Only the lane offset derived from the mask reaches HADDR[1:0].
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, mem_addr[1:0]};

  always_comb begin
    dec_size = SZ_WORD;
    dec_off  = 2'b00;
    case (mem_wmask)
      4'b0011: dec_size = SZ_HALF;
      4'b1100: begin dec_size = SZ_HALF; dec_off = 2'b10; end
      4'b0001: dec_size = SZ_BYTE;
      4'b0010: begin dec_size = SZ_BYTE; dec_off = 2'b01; end
      4'b0100: begin dec_size = SZ_BYTE; dec_off = 2'b10; end
      4'b1000: begin dec_size = SZ_BYTE; dec_off = 2'b11; end
      default: ;
    endcase
  end

`ifdef FEMTO_AHB_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // Counts HREADY=0 cycles of the current data phase; aborts on the last allowed one.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_abort = 1'b0;
    if (state_q == S_ADDR) begin
      tmo_cnt_d = 16'd0;
    end else if (state_q == S_DATA && !HREADY) begin
      if (tmo_cnt_q == TMO_LAST) tmo_abort = 1'b1;
      else                       tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt_q <= 16'd0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_abort = 1'b0;
`endif

  // CPU side: a request is a one-cycle rstrb or nonzero wmask while sel=1 and idle;
  // the matching busy is high from the next cycle until the data phase completes.
  assign wr_req   = |mem_wmask;
  assign req      = sel && (mem_rstrb || wr_req);
  assign xfer_end = (state_q == S_DATA) && (HREADY || tmo_abort);

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    rbusy_d  = rbusy_q;
    wbusy_d  = wbusy_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_ADDR;
          haddr_d  = {mem_addr[31:2], dec_off};
          hwrite_d = wr_req;
          hsize_d  = dec_size;
          if (wr_req) begin
            hwdata_d = mem_wdata;
            wbusy_d  = 1'b1;
          end else begin
            rbusy_d  = 1'b1;
          end
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        if (HRESP || tmo_abort) err_d = 1'b1;
        if (xfer_end) begin
          state_d = S_IDLE;
          rbusy_d = 1'b0;
          wbusy_d = 1'b0;
          if (!hwrite_q) rdata_d = (HRESP || tmo_abort) ? ERR_RDATA : HRDATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      haddr_q  <= 32'd0;
      hwrite_q <= 1'b0;
      hsize_q  <= SZ_WORD;
      hwdata_q <= 32'd0;
      rdata_q  <= 32'd0;
      rbusy_q  <= 1'b0;
      wbusy_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      rbusy_q  <= rbusy_d;
      wbusy_q  <= wbusy_d;
      err_q    <= err_d;
    end
  end

  assign HTRANS      = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR       = haddr_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HWDATA      = hwdata_q;
  assign mem_rdata   = rdata_q;
  assign mem_rbusy   = rbusy_q;
  assign mem_wbusy   = wbusy_q;
  assign err_sticky  = err_q;
  assign dbg_state_o = state_q;

endmodule
